// File: rtl/toggle_pkg.sv
// Shared types and defaults for the push-button / divider toggle pulse generator.
package toggle_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } db_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer plus debounce FSM; btn_stable follows btn_in only after
// DEBOUNCE_CYCLES consecutive disagreeing synchronized samples.
//
// state        | meaning
// ST_LOW       | debounced level is 0, input agrees
// ST_WAIT_HIGH | debounced level is 0, counting samples at 1
// ST_HIGH      | debounced level is 1, input agrees
// ST_WAIT_LOW  | debounced level is 1, counting samples at 0
module sync_debounce
  import toggle_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             btn_sync_q, btn_sync_d;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  always_comb begin
    s1_d       = btn_in;
    btn_sync_d = s1_q;
    state_d    = state_q;
    cnt_d      = '0;
    stable_d   = stable_q;
    case (state_q)
      ST_LOW: begin
        if (btn_sync_q) begin
          state_d = ST_WAIT_HIGH;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_WAIT_HIGH: begin
        if (!btn_sync_q) begin
          state_d = ST_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_HIGH;
          stable_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!btn_sync_q) begin
          state_d = ST_WAIT_LOW;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_WAIT_LOW: begin
        if (btn_sync_q) begin
          state_d = ST_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_LOW;
          stable_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = ST_LOW;
        stable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= 1'b0;
      btn_sync_q <= 1'b0;
      state_q    <= ST_LOW;
      cnt_q      <= '0;
      stable_q   <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      btn_sync_q <= btn_sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stable_q   <= stable_d;
    end
  end

  assign btn_stable = stable_q;

endmodule

// File: rtl/toggle_pulse_gen.sv
// Turns debounced button presses and optional divider ticks into one-cycle T pulses.
// Define TOGGLE_DIVIDER_EN to build the periodic divider; otherwise div_en/div_val are ignored.
module toggle_pulse_gen
  import toggle_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned DIV_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_in,
  input  logic                 div_en,
  input  logic [DIV_WIDTH-1:0] div_val,
  output logic                 T,
  output logic                 btn_stable
);

  logic btn_stable_d_q, btn_stable_d_d;
  logic t_q, t_d;
  logic press;
  logic tick;

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .btn_stable(btn_stable)
  );

`ifdef TOGGLE_DIVIDER_EN
  logic                 div_en_q, div_en_d;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_WIDTH-1:0] div_val_q, div_val_d;
  logic                 div_rise;

  // Counting starts the cycle after div_en is first seen, so the first tick
  // lands div_val+1 edges after that.
  always_comb begin
    div_en_d  = div_en;
    div_rise  = div_en & ~div_en_q;
    tick      = div_en & div_en_q & (div_cnt_q == div_val_q);
    div_cnt_d = (div_en & div_en_q & ~tick) ? div_cnt_q + DIV_WIDTH'(1) : '0;
    div_val_d = (div_rise | tick) ? div_val : div_val_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_en_q  <= 1'b0;
      div_cnt_q <= '0;
      div_val_q <= '0;
    end else begin
      div_en_q  <= div_en_d;
      div_cnt_q <= div_cnt_d;
      div_val_q <= div_val_d;
    end
  end
`else
  logic unused_div;
  assign unused_div = ^{div_en, div_val};
  assign tick       = 1'b0;
`endif

  always_comb begin
    btn_stable_d_d = btn_stable;
    press          = btn_stable & ~btn_stable_d_q;
    t_d            = press | tick;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_stable_d_q <= 1'b0;
      t_q            <= 1'b0;
    end else begin
      btn_stable_d_q <= btn_stable_d_d;
      t_q            <= t_d;
    end
  end

  assign T = t_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Directed and randomized bench for toggle_pulse_gen against an edge-indexed
// history model of the button path and a next-tick schedule for the divider.
module tb_toggle_pulse_gen;

  localparam int D    = 16;
  localparam int MAXE = 8192;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_in = 1'b0;
  logic       div_en = 1'b0;
  logic [7:0] div_val = 8'd0;
  logic       T;
  logic       btn_stable;

  toggle_pulse_gen #(
    .DEBOUNCE_CYCLES(D),
    .DIV_WIDTH      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .div_en    (div_en),
    .div_val   (div_val),
    .T         (T),
    .btn_stable(btn_stable)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  int   n = 0;
  bit   hist [0:MAXE-1];
  int   last_flip = 0;
  bit   st_cur = 1'b0;
  bit   st_old = 1'b0;
  bit   t_exp  = 1'b0;
`ifdef TOGGLE_DIVIDER_EN
  bit   en_prev = 1'b0;
  int   next_tick = 0;
`endif

  int pulse_cnt   = 0;
  int first_t_edge = -1;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s edge=%0d got=%0d expected=%0d", tag, n, obs, exp);
  endtask

  // Advance the reference by one rising edge with the inputs it sampled.
  task automatic model_edge(input bit r, input bit b, input bit e, input logic [7:0] v);
    bit press, tick, flip;
    n++;
    if (r) begin
      hist[n]   = 1'b0;
      hist[n-1] = 1'b0;
      last_flip = n;
      st_cur    = 1'b0;
      st_old    = 1'b0;
      t_exp     = 1'b0;
`ifdef TOGGLE_DIVIDER_EN
      en_prev   = 1'b0;
`endif
    end else begin
      hist[n] = b;
      press   = st_cur & ~st_old;
      tick    = 1'b0;
`ifdef TOGGLE_DIVIDER_EN
      if (e) begin
        if (!en_prev) next_tick = n + int'(v) + 1;
        else if (n == next_tick) begin
          tick      = 1'b1;
          next_tick = n + int'(v) + 1;
        end
      end
      en_prev = e;
`endif
      // synchronized sample seen at edge k is the raw level sampled at k-2
      flip = (n - last_flip >= D);
      if (flip) begin
        for (int j = 0; j < D; j++)
          if (hist[n-j-2] == st_cur) flip = 1'b0;
      end
      t_exp  = press | tick;
      st_old = st_cur;
      if (flip) begin
        st_cur    = ~st_cur;
        last_flip = n;
      end
    end
  endtask

  task automatic step(input bit r, input bit b, input bit e, input logic [7:0] v);
    rst = r; btn_in = b; div_en = e; div_val = v;
    @(posedge clk);
    model_edge(r, b, e, v);
    #1;
    check("T", int'(T), int'(t_exp));
    check("btn_stable", int'(btn_stable), int'(st_cur));
    if (T === 1'b1) begin
      pulse_cnt++;
      if (first_t_edge < 0) first_t_edge = n;
    end
  endtask

  task automatic phase_start();
    pulse_cnt    = 0;
    first_t_edge = -1;
  endtask

  initial begin
    int s;
    int run_left;
    bit rb, re;
    logic [7:0] rv;

    repeat (3) step(1, 0, 0, 0);

    phase_start();
    repeat (50) step(0, 0, 0, 0);
    check("idle_pulses", pulse_cnt, 0);

    // clean press held for 40 cycles, then release
    phase_start();
    s = n + 1;
    repeat (40) step(0, 1, 0, 0);
    check("press_pulses", pulse_cnt, 1);
    check("press_latency", first_t_edge - s, D + 2);
    phase_start();
    repeat (40) step(0, 0, 0, 0);
    check("release_pulses", pulse_cnt, 0);

    // bouncing press
    phase_start();
    repeat (4) begin
      repeat (5) step(0, 1, 0, 0);
      repeat (3) step(0, 0, 0, 0);
    end
    s = n + 1;
    repeat (40) step(0, 1, 0, 0);
    check("bounce_pulses", pulse_cnt, 1);
    check("bounce_latency", first_t_edge - s, D + 2);
    repeat (40) step(0, 0, 0, 0);

    // glitch one sample short of qualifying
    phase_start();
    repeat (D - 1) step(0, 1, 0, 0);
    repeat (30) step(0, 0, 0, 0);
    check("glitch_pulses", pulse_cnt, 0);

    // divider: period 4, mid-period change to 1, then 0
    repeat (10) step(0, 0, 1, 8'd3);
    repeat (10) step(0, 0, 1, 8'd1);
    repeat (8)  step(0, 0, 1, 8'd0);
    repeat (5)  step(0, 0, 0, 8'd0);

    // divider period 9 started with the press: tick meets press at edge s+18
    repeat (40) step(0, 1, 1, 8'd8);
    repeat (40) step(0, 0, 0, 8'd2);

    // non-divider style stimulus: div_en high with div_val 2 and a press
    repeat (12) step(0, 0, 1, 8'd2);
    repeat (30) step(0, 1, 1, 8'd2);
    repeat (30) step(0, 0, 0, 8'd2);

    // reset at debounce count 10 with the button held through it
    phase_start();
    repeat (12) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    s = n + 1;
    repeat (30) step(0, 1, 0, 0);
    check("rst_requal_pulses", pulse_cnt, 1);
    check("rst_requal_latency", first_t_edge - s, D + 2);
    repeat (30) step(0, 0, 0, 0);

    // randomized traffic
    run_left = 0; rb = 1'b0; re = 1'b0; rv = 8'd0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        rb = ~rb;
        run_left = $urandom_range(1, 40);
      end
      run_left--;
      if ($urandom_range(0, 99) < 2) re = ~re;
      if ($urandom_range(0, 99) < 10) rv = 8'($urandom_range(0, 12));
      step(($urandom_range(0, 999) < 3), rb, re, rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/toggle_pulse_gen.md
# toggle_pulse_gen

Upstream stage for the T flip-flop: turns a raw, bouncing push-button into clean single-cycle toggle pulses on `T`, and can optionally generate periodic toggle pulses from a programmable divider. Its `T` output connects directly to the flip-flop's `T` input on the same `clk`. Each accepted button press, or each divider terminal count, produces exactly one toggle of Q/Qn.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronized samples required to accept a level change; legal range 2..65535.
- `DIV_WIDTH`, 8: width of the divider reload value.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `btn_in`  in  1  raw asynchronous button level; high means pressed.
- `div_en`  in  1  enable for periodic pulse generation.
- `div_val`  in  `DIV_WIDTH`  period minus one, in clk cycles.
- `T`  out  1  registered one-cycle toggle pulse to the T flip-flop.
- `btn_stable`  out  1  debounced button level.

## Operation
- Synchronizer: two flops, `btn_in` -> `s1` -> `btn_sync`. Neither flop is reset-gated in logic, but both clear to 0 on `rst`.
- Debounce FSM states:
  - `ST_LOW`: `btn_stable` = 0.
  - `ST_WAIT_HIGH`: counting toward 1.
  - `ST_HIGH`: `btn_stable` = 1.
  - `ST_WAIT_LOW`: counting toward 0.
- Debounce counter, width `$clog2(DEBOUNCE_CYCLES+1)`:
  - Increments on each cycle where `btn_sync` != `btn_stable`.
  - Clears to 0 on any cycle where they match. A bounce returns the FSM to `ST_LOW` or `ST_HIGH`.
  - On the `DEBOUNCE_CYCLES`-th consecutive mismatching sample, `btn_stable` flips, the FSM enters `ST_HIGH` or `ST_LOW`, and the counter clears.
- Press pulse: `press = btn_stable & ~btn_stable_d`. Rising edge only; releases generate nothing.
- Divider:
  - `div_cnt` is held at 0 while `div_en` = 0.
  - While `div_en` = 1, `div_cnt` counts 0..`div_val_q` and then wraps to 0. `tick` is asserted in the wrap cycle.
  - `div_val_q` is loaded from `div_val` when `div_en` rises and at every wrap. A mid-period change to `div_val` takes effect from the next period.
  - `div_val` = 0 gives `tick` every cycle.
- Output: `T <= press | tick`. A press and a tick in the same cycle yield one pulse; there is no double toggle and no queuing.
- Reset values: `T` = 0, `btn_stable` = 0, FSM = `ST_LOW`, all counters 0, `div_val_q` = 0.
- Reset mid-operation:
  - Any in-progress debounce is discarded.
  - A button held through reset release is re-qualified from scratch and produces one pulse after the full latency.

## Timing
- Edge 0 is the first clk edge that samples `btn_in` = 1.
- The input is held steady from edge 0 onward.
- `btn_sync` = 1 after edge 1.
- `btn_stable` = 1 after edge `DEBOUNCE_CYCLES`+1.
- `T` = 1 for exactly one cycle, after edge `DEBOUNCE_CYCLES`+2.
- Divider: with `div_en` rising before edge 0, `T` pulses after edges `div_val`+1, 2·(`div_val`+1), and so on. One `T` pulse per period, one cycle wide.
- Pulses shorter than `DEBOUNCE_CYCLES` cycles at `btn_sync` are rejected completely.

## Configuration
- `TOGGLE_DIVIDER_EN` defined: the divider is built and `div_en`/`div_val` are functional.
- `TOGGLE_DIVIDER_EN` not defined:
  - The divider logic is omitted and `tick` is tied to 0.
  - `div_en`/`div_val` remain as ports but are ignored, so the port list is unchanged.
  - `T` carries button pulses only.

## Structure
- Package `toggle_pkg` holds:
  - the debounce FSM state enum (2-bit encoding `ST_LOW`, `ST_WAIT_HIGH`, `ST_HIGH`, `ST_WAIT_LOW`);
  - the default `DEBOUNCE_CYCLES` constant.
- Sub-module `sync_debounce` contains the synchronizer, debounce FSM and counter, and outputs `btn_stable`.
- Top-level `toggle_pulse_gen` contains the edge detect, divider and `T` register.

## Test plan
- Reset, `btn_in` = 0, `div_en` = 0 for 50 cycles -> `T` = 0 and `btn_stable` = 0 throughout.
- `DEBOUNCE_CYCLES` = 16, clean press at edge 0 held for 40 cycles -> single `T` pulse after edge 18, `btn_stable` high after edge 17, no pulse on release.
- Bouncing press (high 5 cycles, low 3 cycles, repeated 4 times, then held) -> exactly one `T` pulse, occurring 18 edges after the final rise. Glitches of 15 cycles produce no pulse.
- `div_en` = 1, `div_val` = 3 -> `T` pulses every 4 cycles. Changing `div_val` to 1 mid-period keeps the current period at 4, then pulses every 2 cycles. `div_val` = 0 gives `T` high every cycle.
- Press qualifying in the same cycle as a divider tick -> one `T` pulse. `rst` asserted at debounce count 10 -> counter cleared and no pulse; held button re-qualifies after 18 edges.
- Build without `TOGGLE_DIVIDER_EN`, `div_en` = 1, `div_val` = 2 -> no periodic pulses; button pulses still generated.
